// File: rtl/inst_encoder.sv
// RV32I instruction encoder: field-level requests in, assembled 32-bit words out (valid/ready).
// Define ENCODER_LI_EXPAND_EN to expand the LI pseudo (fmt 6) into ADDI or LUI+ADDI.
module inst_encoder #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_fmt,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_f3,
  input  logic [6:0]           i_f7,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [31:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_inst,
  output logic                 o_err,
  output logic                 o_last,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtLi  = 3'd6;
  localparam logic [2:0] FmtRsv = 3'd7;

`ifdef ENCODER_LI_EXPAND_EN
  localparam logic [6:0] OpLui  = 7'h37;
  localparam logic [6:0] OpImm  = 7'h13;
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLiLo = 1'b1;
`endif

  // Signed range checks: upper bits must be a pure sign extension.
  logic imm_fits12;
  logic imm_fits13;
  logic imm_fits21;

  assign imm_fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign imm_fits13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign imm_fits21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  logic [31:0] word_r;
  logic [31:0] word_i;
  logic [31:0] word_s;
  logic [31:0] word_b;
  logic [31:0] word_u;
  logic [31:0] word_j;

  assign word_r = {i_f7, i_rs2, i_rs1, i_f3, i_rd, i_opcode};
  assign word_i = {i_imm[11:0], i_rs1, i_f3, i_rd, i_opcode};
  assign word_s = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], i_opcode};
  assign word_b = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3, i_imm[4:1], i_imm[11],
                   i_opcode};
  assign word_u = {i_imm[31:12], i_rd, i_opcode};
  assign word_j = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};

`ifdef ENCODER_LI_EXPAND_EN
  // Rounding the upper part compensates for the sign-extended ADDI low part.
  logic [31:0] li_round;
  logic [31:0] li_lui_word;
  logic [31:0] li_addi_x0_word;
  logic [31:0] li_addi_rd_word;

  assign li_round        = i_imm + 32'h0000_0800;
  assign li_lui_word     = {li_round[31:12], i_rd, OpLui};
  assign li_addi_x0_word = {i_imm[11:0], 5'd0, 3'd0, i_rd, OpImm};
  assign li_addi_rd_word = {i_imm[11:0], i_rd, 3'd0, i_rd, OpImm};
`endif

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        enc_last;

  always_comb begin
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    enc_last = 1'b1;
    unique case (i_fmt)
      FmtR: enc_inst = word_r;
      FmtI: begin
        enc_inst = word_i;
        enc_err  = ~imm_fits12;
      end
      FmtS: begin
        enc_inst = word_s;
        enc_err  = ~imm_fits12;
      end
      FmtB: begin
        enc_inst = word_b;
        enc_err  = ~imm_fits13 | i_imm[0];
      end
      FmtU: begin
        enc_inst = word_u;
        enc_err  = |i_imm[11:0];
      end
      FmtJ: begin
        enc_inst = word_j;
        enc_err  = ~imm_fits21 | i_imm[0];
      end
      FmtLi: begin
`ifdef ENCODER_LI_EXPAND_EN
        if (imm_fits12) begin
          enc_inst = li_addi_x0_word;
        end else begin
          enc_inst = li_lui_word;
          enc_last = 1'b0;
        end
`else
        enc_err = 1'b1;
`endif
      end
      FmtRsv: enc_err = 1'b1;
      default: enc_err = 1'b1;
    endcase
    if (enc_err) begin
      enc_inst = 32'h0;
      enc_last = 1'b1;
    end
  end

  logic                 valid_q, valid_d;
  logic [31:0]          inst_q, inst_d;
  logic                 err_q, err_d;
  logic                 last_q, last_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 st_idle;
  logic                 accept;
  logic                 out_fire;

`ifdef ENCODER_LI_EXPAND_EN
  logic [0:0]  state_q, state_d;
  logic [31:0] lo_inst_q, lo_inst_d;

  assign st_idle = (state_q == StIdle);
`else
  assign st_idle = 1'b1;
`endif

  assign o_ready  = st_idle & (~valid_q | i_ready);
  assign accept   = i_valid & o_ready;
  assign out_fire = valid_q & i_ready;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    err_d     = err_q;
    last_d    = last_q;
    err_cnt_d = err_cnt_q;
`ifdef ENCODER_LI_EXPAND_EN
    state_d   = state_q;
    lo_inst_d = lo_inst_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      inst_d  = enc_inst;
      err_d   = enc_err;
      last_d  = enc_last;
      if (enc_err && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
`ifdef ENCODER_LI_EXPAND_EN
      if (!enc_last) begin
        state_d   = StLiLo;
        lo_inst_d = li_addi_rd_word;
      end
`endif
    end else if (out_fire) begin
`ifdef ENCODER_LI_EXPAND_EN
      if (state_q == StLiLo) begin
        inst_d  = lo_inst_q;
        err_d   = 1'b0;
        last_d  = 1'b1;
        state_d = StIdle;
      end else begin
        valid_d = 1'b0;
      end
`else
      valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      inst_q    <= 32'h0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      last_q    <= last_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef ENCODER_LI_EXPAND_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      lo_inst_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      lo_inst_q <= lo_inst_d;
    end
  end
`endif

  assign o_valid   = valid_q;
  assign o_inst    = inst_q;
  assign o_err     = err_q;
  assign o_last    = last_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words queued on request, checked on output transfer.
module tb_inst_encoder;

  localparam int unsigned ERR_CNT_W = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [2:0]           i_fmt;
  logic [6:0]           i_opcode;
  logic [2:0]           i_f3;
  logic [6:0]           i_f7;
  logic [4:0]           i_rd;
  logic [4:0]           i_rs1;
  logic [4:0]           i_rs2;
  logic [31:0]          i_imm;
  logic                 o_valid;
  logic                 i_ready;
  logic [31:0]          o_inst;
  logic                 o_err;
  logic                 o_last;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  inst_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_fmt    (i_fmt),
    .i_opcode (i_opcode),
    .i_f3     (i_f3),
    .i_f7     (i_f7),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_imm    (i_imm),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_inst   (o_inst),
    .o_err    (o_err),
    .o_last   (o_last),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] ei, input logic ee, input logic el);
    exp_t e;
    e.inst = ei;
    e.err  = ee;
    e.last = el;
    sb.push_back(e);
  endtask

  // Drive one request, queue its expected word, wait (bounded) for acceptance.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee, input logic el);
    logic acc;
    int   n;
    i_fmt    = fmt;
    i_opcode = op;
    i_f3     = f3;
    i_f7     = f7;
    i_rd     = rd;
    i_rs1    = rs1;
    i_rs2    = rs2;
    i_imm    = imm;
    i_valid  = 1'b1;
    push(ei, ee, el);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    check("accept", {31'd0, acc}, 32'd1);
    if (acc && ee && exp_cnt < 255) exp_cnt++;
    i_valid = 1'b0;
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("inst", o_inst, e.inst);
        check("err", {31'd0, o_err}, {31'd0, e.err});
        check("last", {31'd0, o_last}, {31'd0, e.last});
      end
    end
  end

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_fmt    = '0;
    i_opcode = '0;
    i_f3     = '0;
    i_f7     = '0;
    i_rd     = '0;
    i_rs1    = '0;
    i_rs2    = '0;
    i_imm    = '0;

    #12;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    check("rst_cnt", {24'd0, o_err_cnt}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Legal words, back to back; unused fields are driven nonzero where possible.
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1);
    check("lat_valid", {31'd0, o_valid}, 32'd1);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd9, 32'd5, 32'h00500093, 1'b0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2048, 32'h80000093, 1'b0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF00093, 1'b0, 1'b1);
    send(3'd2, 7'h23, 3'd2, 7'h55, 5'd7, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0, 1'b1);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd3, 5'd0, 32'h800, 32'h001000EF, 1'b0, 1'b1);
    send(3'd4, 7'h37, 3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd7, 5'd1, 5'd2, -32'sd4096, 32'h80208063, 1'b0, 1'b1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4094, 32'h7E208FE3, 1'b0, 1'b1);
    check("cnt_legal", {24'd0, o_err_cnt}, exp_cnt);

    // Unencodable requests.
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 1'b1, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b1, 1'b1);
    check("cnt_two", {24'd0, o_err_cnt}, exp_cnt);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h0, 1'b1, 1'b1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h0, 1'b1, 1'b1);
    send(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b1);

`ifdef ENCODER_LI_EXPAND_EN
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h123462B7, 1'b0, 1'b0);
    push(32'hFFF28293, 1'b0, 1'b1);
    @(negedge i_clk);
    check("li_ready_low", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk);
    #1;
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, 1'b1);
`else
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h0, 1'b1, 1'b1);
`endif
    check("cnt_errs", {24'd0, o_err_cnt}, exp_cnt);

    // Backpressure: first word held, second request waits until i_ready returns.
    repeat (3) @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1);
    i_fmt    = 3'd1;
    i_opcode = 7'h13;
    i_f3     = 3'd0;
    i_f7     = 7'h00;
    i_rd     = 5'd1;
    i_rs1    = 5'd0;
    i_rs2    = 5'd0;
    i_imm    = 32'd5;
    i_valid  = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      check("bp_inst", o_inst, 32'h002081B3);
      check("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("bp_release_ready", {31'd0, o_ready}, 32'd1);
    push(32'h00500093, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;

    // Saturate the error counter.
    repeat (260) begin
      send(3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1, 1'b1);
    end
    check("cnt_sat", {24'd0, o_err_cnt}, 32'd255);

    // Asynchronous reset with a word stalled at the output.
    repeat (3) @(posedge i_clk);
    #1;
    i_ready = 1'b0;
`ifdef ENCODER_LI_EXPAND_EN
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h123462B7, 1'b0, 1'b0);
`else
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1);
`endif
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_cnt", {24'd0, o_err_cnt}, 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b1, 1'b1);
    check("post_rst_cnt", {24'd0, o_err_cnt}, exp_cnt);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge i_clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
